mem_access_master: RTL



---
 rtl/mem_access_pkg.sv | 29 ++
 rtl/mem_subword_align.sv | 38 +++
 rtl/mem_access_master.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store initiator: access sizes, FSM states and the default RAM limit.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    localparam logic [31:0] ADDR_LIMIT_DEFAULT = 32'h0000_1000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WR     = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_t;

    // Bytes touched by an access; the reserved size is rejected elsewhere, so its value is arbitrary.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            default:   size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_subword_align.sv
// Big-endian sub-word handling: extracts/extends load data and merges sub-word store data
// into the word read back from the RAM (byte at the access address is the MSB).
module mem_subword_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic w_sign;

    always_comb begin
        o_load_data  = i_rdata;
        o_merge_data = i_wdata;
        w_sign       = 1'b0;
        case (i_size)
            SIZE_BYTE: begin
                w_sign       = !i_unsigned && i_rdata[31];
                o_load_data  = {{24{w_sign}}, i_rdata[31:24]};
                o_merge_data = {i_wdata[7:0], i_rdata[23:0]};
            end
            SIZE_HALF: begin
                w_sign       = !i_unsigned && i_rdata[31];
                o_load_data  = {{16{w_sign}}, i_rdata[31:16]};
                o_merge_data = {i_wdata[15:0], i_rdata[15:0]};
            end
            default: begin
                o_load_data  = i_rdata;
                o_merge_data = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_master.sv
// Single-outstanding load/store initiator for the big-endian 32-bit word RAM; sub-word stores use read-modify-write.
// Build option: define MISALIGN_TRAP_EN to reject misaligned half/word accesses with resp_err.
module mem_access_master
    import mem_access_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_address,
    output logic        ram_read_enable,
    output logic        ram_write_enable,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data
);

    state_t      r_state;
    state_t      w_state_next;

    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_merged;
    logic [31:0] r_load_data;

    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;

    logic        w_accept;
    logic        w_req_err;
    logic        w_range_err;
    logic        w_misalign;
    logic [32:0] w_last_byte;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    logic        w_ram_rd;
    logic        w_ram_wr;
    logic [31:0] w_ram_addr;
    logic [31:0] w_ram_wdata;

    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    // 33-bit end address so an access wrapping past 0xFFFFFFFF is caught as out of range.
    assign w_last_byte = {1'b0, req_addr} + {30'd0, size_bytes(req_size)} - 33'd1;
    assign w_range_err = w_last_byte > {1'b0, ADDR_LIMIT};

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((req_size == SIZE_HALF) && req_addr[0]) ||
                        ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_req_err = (req_size == SIZE_RSVD) || w_range_err || w_misalign;

    mem_subword_align u_align (
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_rdata      (ram_read_data),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    always_comb begin
        w_state_next = r_state;
        w_ram_rd     = 1'b0;
        w_ram_wr     = 1'b0;
        w_ram_addr   = 32'd0;
        w_ram_wdata  = 32'd0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req_err)
                        w_state_next = RESP;
                    else if (!req_write)
                        w_state_next = RD;
                    else if (req_size == SIZE_WORD)
                        w_state_next = WR;
                    else
                        w_state_next = RMW_RD;
                end
            end
            RD: begin
                w_ram_rd     = 1'b1;
                w_ram_addr   = r_addr;
                w_state_next = RESP;
            end
            WR: begin
                w_ram_wr     = 1'b1;
                w_ram_addr   = r_addr;
                w_ram_wdata  = r_wdata;
                w_state_next = RESP;
            end
            RMW_RD: begin
                w_ram_rd     = 1'b1;
                w_ram_addr   = r_addr;
                w_state_next = RMW_WR;
            end
            RMW_WR: begin
                w_ram_wr     = 1'b1;
                w_ram_addr   = r_addr;
                w_ram_wdata  = r_merged;
                w_state_next = RESP;
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_write      <= 1'b0;
            r_size       <= 2'd0;
            r_unsigned   <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_err        <= 1'b0;
            r_merged     <= 32'd0;
            r_load_data  <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
        end else begin
            r_state <= w_state_next;

            // Response is registered out of RESP, so it lands in the following IDLE cycle.
            r_resp_valid <= (r_state == RESP);
            r_resp_err   <= (r_state == RESP) && r_err;
            r_resp_rdata <= ((r_state == RESP) && !r_err && !r_write) ? r_load_data : 32'd0;

            if (w_accept) begin
                r_write     <= req_write;
                r_size      <= req_size;
                r_unsigned  <= req_unsigned;
                r_addr      <= req_addr;
                r_wdata     <= req_wdata;
                r_err       <= w_req_err;
                r_load_data <= 32'd0;
            end

            if (r_state == RD)
                r_load_data <= w_load_data;

            if (r_state == RMW_RD)
                r_merged <= w_merge_data;
        end
    end

    assign resp_valid       = r_resp_valid;
    assign resp_err         = r_resp_err;
    assign resp_rdata       = r_resp_rdata;
    assign ram_address      = w_ram_addr;
    assign ram_read_enable  = w_ram_rd;
    assign ram_write_enable = w_ram_wr;
    assign ram_write_data   = w_ram_wdata;

endmodule
